pipe_seg_buf: RTL and testbench
===============================

// Module: pipe_seg_buf
// PURPOSE
//  Parametrised pipeline segment register with a valid/ready handshake, an optional 2-entry skid
//  buffer, synchronous flush and a per-field clear mask. Drop-in successor for the fixed
//  EX/MEM and MEM/WB segment registers, which are widened and only have a global stall.
//  Producer stage drives in_*; consumer stage drives out_ready. Flush comes from the
//  exception/eret logic.
// PARAMETERS
//  DATA_W    256  payload width: concatenated pc/alu/ram/rdata/hilo/cp0 fields
//  SKID      1    1 = 2-entry skid (registered in_ready); 0 = single register (comb in_ready)
//  CLR_MASK  0    DATA_W mask of payload bits forced to 0 when in_clr=1 at capture
//  CNT_W     16   width of the stall-cycle counter
// PORTS
//  clk        in   1       clock, rising edge
//  resetn     in   1       asynchronous active-low reset
//  flush      in   1       synchronous kill of all held entries (int_flush)
//  in_valid   in   1       producer has a payload
//  in_ready   out  1       buffer accepts a payload this cycle
//  in_data    in   DATA_W  producer payload
//  in_clr     in   1       apply CLR_MASK to this capture (e.g. div_finish clears cp0 tag)
//  out_valid  out  1       out_data holds a live payload
//  out_ready  in   1       consumer takes out_data this cycle
//  out_data   out  DATA_W  head payload (main register)
//  occupancy  out  2       entries held: 0, 1 or 2
//  stall_cnt  out  CNT_W   saturating count of cycles with out_valid & ~out_ready
//  cnt_clr    in   1       synchronous clear of stall_cnt
// BEHAVIOUR
//  - in_fire = in_valid & in_ready; out_fire = out_valid & out_ready. cap = in_data & ~(in_clr ? CLR_MASK : 0).
//  - Reset (async, resetn=0): state EMPTY, main=skid=0, out_valid=0, out_data=0,
//    occupancy=0, stall_cnt=0, in_ready=1 (SKID=1) or 1 via comb (SKID=0).
//  - States: EMPTY (occ 0), ONE (main live, occ 1), TWO (main+skid live, occ 2; SKID=1 only).
//  - EMPTY: in_fire -> ONE, main<=cap. Else stay.
//  - ONE: in_fire&out_fire -> ONE, main<=cap. in_fire&~out_fire -> TWO (SKID=1), skid<=cap.
//    ~in_fire&out_fire -> EMPTY. Else hold.
//  - TWO: in_ready=0. out_fire -> ONE, main<=skid. Order is preserved: skid never bypasses main.
//  - in_ready: SKID=1 -> registered, =(next state != TWO). SKID=0 -> ~out_valid | out_ready
//    (comb). SKID=0 never enters TWO.
//  - Latency: capture-to-out_valid 1 cycle. Full throughput (1 payload/cycle) with out_ready=1.
//  - flush: highest priority over in_fire and out_fire. Next state EMPTY, main=skid=0, out_valid=0.
//    A same-cycle in payload is dropped. A same-cycle out_fire counts as delivered.
//    in_ready goes 1 the next cycle.
//  - On drain to EMPTY (no flush), main retains its last value. out_data is don't-care while out_valid=0.
//  - stall_cnt: +1 each cycle out_valid&~out_ready. Saturates at 2^CNT_W-1, no wrap.
//    cnt_clr wins over increment. Unaffected by flush.
//  - Reset asserted mid-transfer: all state cleared immediately. No payload survives.
//  - X on in_data with in_valid=0 must not propagate to out_data.
// TESTING
//  1 reset, in_valid=1 data=0xA5.. for 4 cycles, out_ready=1 -> out_valid from cycle 1,
//    out_data A5.. each cycle, occupancy 1, stall_cnt 0.
//  2 SKID=1: push D1,D2 with out_ready=0 -> occ=2, in_ready=0, stall_cnt counts;
//    then out_ready=1 -> D1 then D2, occ 2->1->0.
//  3 in_clr=1, CLR_MASK=1<<255, in_data bit255=1 -> out_data bit255=0, other bits unchanged.
//  4 occ=2 plus flush with in_valid=1 D3 -> next cycle out_valid=0, occ=0, in_ready=1;
//    D3 never appears.
//  5 SKID=0, out_valid=1, out_ready toggling -> in_ready == out_ready same cycle; no loss or duplication.
//  6 CNT_W=4, hold out_ready=0 for 20 cycles -> stall_cnt stops at 15; cnt_clr -> 0 next cycle.

Source files
------------

// File: rtl/pipe_seg_buf_if.sv
// pipe_seg_buf_if: handshake bundle for one pipeline segment buffer.
//   in_valid / in_ready / in_data / in_clr : producer -> buffer
//   out_valid / out_ready / out_data       : buffer -> consumer
// Handshake: a transfer happens on a rising clk edge where valid & ready are
// both 1. Valid may not depend on ready, and data must be stable while
// valid=1 and ready=0. Ready may be asserted without valid.
// Modports: slave = the buffer itself, master = the surrounding stages.
interface pipe_seg_buf_if #(
  parameter int DATA_W = 256
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_clr;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;

  modport slave (
    input  in_valid, in_data, in_clr, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, in_clr, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

// File: rtl/pipe_seg_buf.sv
// pipe_seg_buf: pipeline segment register with valid/ready handshake,
// optional 2-entry skid buffer, synchronous flush, per-field clear mask and
// a saturating stall-cycle counter.
// Ports:
//   clk        rising-edge clock
//   resetn     asynchronous active-low reset
//   flush      synchronous kill of all held entries
//   cnt_clr    synchronous clear of stall_cnt
//   bus        pipe_seg_buf_if.slave (in_* from producer, out_* to consumer)
//   occupancy  entries held: 0, 1 or 2
//   stall_cnt  saturating count of cycles with out_valid & ~out_ready
//   dbg_state  current FSM state (0 EMPTY, 1 ONE, 2 TWO)
module pipe_seg_buf #(
  parameter int                DATA_W   = 256,
  parameter int                SKID     = 1,
  parameter logic [DATA_W-1:0] CLR_MASK = '0,
  parameter int                CNT_W    = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic             cnt_clr,
  pipe_seg_buf_if.slave    bus,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t            state_q;
  logic [DATA_W-1:0] main_q;
  logic [DATA_W-1:0] skid_q;
  logic              out_valid_q;
  logic [1:0]        occ_q;
  logic              in_ready_q;
  logic [CNT_W-1:0]  stall_q;

  logic              in_ready_c;
  logic              in_fire;
  logic              out_fire;
  logic [DATA_W-1:0] cap;

  // With the skid entry, in_ready is a register (breaks the ready path back
  // to the producer). Without it, ready passes straight through from the
  // consumer, so a full register can still accept when it is being drained.
  always_comb begin
    in_ready_c = 1'b0;
    if (SKID != 0) begin
      in_ready_c = in_ready_q;
    end else begin
      in_ready_c = ~out_valid_q | bus.out_ready;
    end
  end

  assign in_fire  = bus.in_valid & in_ready_c;
  assign out_fire = out_valid_q & bus.out_ready;
  assign cap      = bus.in_data & ~(bus.in_clr ? CLR_MASK : '0);

  // Main FSM: main_q is always the head, skid_q only ever holds the entry
  // behind it, so ordering is preserved by construction.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      out_valid_q <= 1'b0;
      occ_q       <= 2'd0;
      in_ready_q  <= 1'b1;
    end else if (flush) begin
      // Flush beats both handshakes: an incoming payload is dropped, an
      // outgoing one was already seen by the consumer this cycle.
      state_q     <= ST_EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      out_valid_q <= 1'b0;
      occ_q       <= 2'd0;
      in_ready_q  <= 1'b1;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            main_q      <= cap;
            state_q     <= ST_ONE;
            out_valid_q <= 1'b1;
            occ_q       <= 2'd1;
            in_ready_q  <= 1'b1;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            main_q <= cap;
          end else if (in_fire && (SKID != 0)) begin
            skid_q     <= cap;
            state_q    <= ST_TWO;
            occ_q      <= 2'd2;
            in_ready_q <= 1'b0;
          end else if (out_fire) begin
            // main_q keeps its last value; out_data is don't-care here.
            state_q     <= ST_EMPTY;
            out_valid_q <= 1'b0;
            occ_q       <= 2'd0;
            in_ready_q  <= 1'b1;
          end
        end
        ST_TWO: begin
          if (out_fire) begin
            main_q     <= skid_q;
            state_q    <= ST_ONE;
            occ_q      <= 2'd1;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= ST_EMPTY;
          out_valid_q <= 1'b0;
          occ_q       <= 2'd0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  // Stall counter: independent of flush, clear wins over increment,
  // saturates at all-ones.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stall_q <= '0;
    end else if (cnt_clr) begin
      stall_q <= '0;
    end else if (out_valid_q && !bus.out_ready && (stall_q != '1)) begin
      stall_q <= stall_q + 1'b1;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = main_q;
  assign occupancy     = occ_q;
  assign stall_cnt     = stall_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_pipe_seg_buf.sv
module tb_pipe_seg_buf;

  localparam int DW = 256;
  localparam logic [DW-1:0] MASK255 = {1'b1, 255'h0};

  localparam logic [DW-1:0] DA   = {32{8'hA5}};
  localparam logic [DW-1:0] D1   = 256'h1111;
  localparam logic [DW-1:0] D2   = 256'h2222;
  localparam logic [DW-1:0] D3   = 256'h3333;
  localparam logic [DW-1:0] D4   = {1'b1, 255'h5};
  localparam logic [DW-1:0] DCI  = {1'b1, 255'hABC};
  localparam logic [DW-1:0] DCO  = {1'b0, 255'hABC};
  localparam logic [DW-1:0] DX   = {DW{1'bx}};

  // ---------------- clock / reset ----------------
  logic clk;
  logic resetn;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- DUTs ----------------
  // u1: skid buffer, 4-bit stall counter, clear mask on bit 255
  // u0: single register, comb in_ready
  pipe_seg_buf_if #(.DATA_W(DW)) bus1 ();
  pipe_seg_buf_if #(.DATA_W(DW)) bus0 ();

  logic       flush1, cnt_clr1, flush0, cnt_clr0;
  logic [1:0] occ1, occ0, st1, st0;
  logic [3:0] stall1;
  logic [15:0] stall0;

  pipe_seg_buf #(.DATA_W(DW), .SKID(1), .CLR_MASK(MASK255), .CNT_W(4)) u1 (
    .clk(clk), .resetn(resetn), .flush(flush1), .cnt_clr(cnt_clr1),
    .bus(bus1.slave), .occupancy(occ1), .stall_cnt(stall1), .dbg_state(st1)
  );

  pipe_seg_buf #(.DATA_W(DW), .SKID(0), .CLR_MASK('0), .CNT_W(16)) u0 (
    .clk(clk), .resetn(resetn), .flush(flush0), .cnt_clr(cnt_clr0),
    .bus(bus0.slave), .occupancy(occ0), .stall_cnt(stall0), .dbg_state(st0)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [DW-1:0] exp_q[$];

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // ---------------- vector table (u1) ----------------
  typedef struct {
    logic          iv;
    logic [DW-1:0] d;
    logic          clr;
    logic          ordy;
    logic          fl;
    logic          cc;
    logic          e_ov;
    logic [DW-1:0] e_d;
    logic          chk_d;
    logic [1:0]    e_occ;
    logic          e_ir;
    logic [3:0]    e_st;
  } vec_t;

  localparam int NV = 19;
  vec_t tbl[NV];

  function automatic vec_t mk(logic iv, logic [DW-1:0] d, logic clr, logic ordy, logic fl,
                              logic cc, logic e_ov, logic [DW-1:0] e_d, logic chk_d,
                              logic [1:0] e_occ, logic e_ir, logic [3:0] e_st);
    vec_t v;
    v.iv = iv; v.d = d; v.clr = clr; v.ordy = ordy; v.fl = fl; v.cc = cc;
    v.e_ov = e_ov; v.e_d = e_d; v.chk_d = chk_d; v.e_occ = e_occ; v.e_ir = e_ir; v.e_st = e_st;
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  // Drive u1 inputs, then advance one clock and settle past the edge.
  task automatic step1(input logic iv, input logic [DW-1:0] d, input logic clr,
                       input logic ordy, input logic fl, input logic cc);
    bus1.in_valid  = iv;
    bus1.in_data   = d;
    bus1.in_clr    = clr;
    bus1.out_ready = ordy;
    flush1         = fl;
    cnt_clr1       = cc;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_u1(input string tag, input logic ov, input logic [1:0] occ,
                        input logic ir, input logic [3:0] st);
    chk({tag, "_out_valid"}, DW'(bus1.out_valid), DW'(ov));
    chk({tag, "_occupancy"}, DW'(occ1), DW'(occ));
    chk({tag, "_in_ready"},  DW'(bus1.in_ready), DW'(ir));
    chk({tag, "_stall_cnt"}, DW'(stall1), DW'(st));
    chk({tag, "_state"},     DW'(st1), DW'(occ));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] vld_pat;
    logic [15:0] rdy_pat;
    logic        m_occ;
    logic        iv0, or0, ir_exp;
    logic [DW-1:0] d0;
    int          k;

    resetn = 1'b0;
    bus1.in_valid = 1'b0; bus1.in_data = '0; bus1.in_clr = 1'b0; bus1.out_ready = 1'b0;
    bus0.in_valid = 1'b0; bus0.in_data = '0; bus0.in_clr = 1'b0; bus0.out_ready = 1'b0;
    flush1 = 1'b0; cnt_clr1 = 1'b0; flush0 = 1'b0; cnt_clr0 = 1'b0;

    // table: inputs, then state right after the edge
    //              iv    d    clr   or    fl    cc    ov    data chk occ   ir    st
    tbl[0]  = mk(1'b1, DA,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, DA,  1'b1, 2'd1, 1'b1, 4'd0);
    tbl[1]  = mk(1'b1, DA,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, DA,  1'b1, 2'd1, 1'b1, 4'd0);
    tbl[2]  = mk(1'b1, DA,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, DA,  1'b1, 2'd1, 1'b1, 4'd0);
    tbl[3]  = mk(1'b1, DA,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, DA,  1'b1, 2'd1, 1'b1, 4'd0);
    tbl[4]  = mk(1'b0, DX,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0,  1'b0, 2'd0, 1'b1, 4'd0);
    tbl[5]  = mk(1'b1, D1,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, D1,  1'b1, 2'd1, 1'b1, 4'd0);
    tbl[6]  = mk(1'b1, D2,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, D1,  1'b1, 2'd2, 1'b0, 4'd1);
    tbl[7]  = mk(1'b1, D3,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, D1,  1'b1, 2'd2, 1'b0, 4'd2);
    tbl[8]  = mk(1'b0, DX,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, D2,  1'b1, 2'd1, 1'b1, 4'd2);
    tbl[9]  = mk(1'b0, DX,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0,  1'b0, 2'd0, 1'b1, 4'd2);
    tbl[10] = mk(1'b0, DX,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0,  1'b0, 2'd0, 1'b1, 4'd0);
    tbl[11] = mk(1'b1, DCI, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, DCO, 1'b1, 2'd1, 1'b1, 4'd0);
    tbl[12] = mk(1'b1, D4,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, DCO, 1'b1, 2'd2, 1'b0, 4'd1);
    tbl[13] = mk(1'b0, DX,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, D4,  1'b1, 2'd1, 1'b1, 4'd1);
    tbl[14] = mk(1'b1, D1,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, D4,  1'b1, 2'd2, 1'b0, 4'd2);
    tbl[15] = mk(1'b1, D3,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0,  1'b1, 2'd0, 1'b1, 4'd3);
    tbl[16] = mk(1'b0, DX,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0,  1'b1, 2'd0, 1'b1, 4'd3);
    tbl[17] = mk(1'b1, D2,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, D2,  1'b1, 2'd1, 1'b1, 4'd3);
    tbl[18] = mk(1'b0, DX,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0,  1'b0, 2'd0, 1'b1, 4'd3);

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk_u1("rst_u1", 1'b0, 2'd0, 1'b1, 4'd0);
    chk("rst_u1_out_data", bus1.out_data, '0);
    chk("rst_u0_out_valid", DW'(bus0.out_valid), DW'(1'b0));
    chk("rst_u0_in_ready", DW'(bus0.in_ready), DW'(1'b1));
    chk("rst_u0_occupancy", DW'(occ0), DW'(2'd0));
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    // table-driven vectors on u1
    for (int i = 0; i < NV; i++) begin
      step1(tbl[i].iv, tbl[i].d, tbl[i].clr, tbl[i].ordy, tbl[i].fl, tbl[i].cc);
      chk_u1($sformatf("vec%0d", i), tbl[i].e_ov, tbl[i].e_occ, tbl[i].e_ir, tbl[i].e_st);
      if (tbl[i].chk_d) chk($sformatf("vec%0d_out_data", i), bus1.out_data, tbl[i].e_d);
    end

    // stall counter saturation: hold out_ready=0 for 20 cycles
    step1(1'b1, D1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("sat_start", DW'(stall1), DW'(4'd0));
    for (int c = 1; c <= 20; c++) begin
      step1(1'b0, DX, 1'b0, 1'b0, 1'b0, 1'b0);
      k = (c > 15) ? 15 : c;
      chk($sformatf("sat_cyc%0d", c), DW'(stall1), DW'(k));
    end
    step1(1'b0, DX, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("sat_cnt_clr", DW'(stall1), DW'(4'd0));
    step1(1'b0, DX, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("sat_after_clr", DW'(stall1), DW'(4'd1));
    chk("sat_data_held", bus1.out_data, D1);
    step1(1'b0, DX, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("sat_drained", DW'(bus1.out_valid), DW'(1'b0));

    // u0 (no skid): comb in_ready follows out_ready while full; order kept
    vld_pat = 16'b1110_1111_0111_1101;
    rdy_pat = 16'b1011_0010_1100_1101;
    m_occ   = 1'b0;
    for (int c = 0; c < 40; c++) begin
      iv0 = vld_pat[c % 16];
      or0 = (c < 32) ? rdy_pat[c % 16] : 1'b1;
      if (c >= 32) iv0 = 1'b0;
      d0  = iv0 ? DW'(32'h100 + c) : DX;
      bus0.in_valid  = iv0;
      bus0.in_data   = d0;
      bus0.out_ready = or0;
      #1;
      ir_exp = ~m_occ | or0;
      chk($sformatf("u0_c%0d_in_ready", c), DW'(bus0.in_ready), DW'(ir_exp));
      chk($sformatf("u0_c%0d_out_valid", c), DW'(bus0.out_valid), DW'(m_occ));
      chk($sformatf("u0_c%0d_occupancy", c), DW'(occ0), DW'(m_occ));
      if (m_occ) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL u0_c%0d_scoreboard actual=out_valid expected=empty", c);
        end else begin
          chk($sformatf("u0_c%0d_out_data", c), bus0.out_data, exp_q[0]);
          if (or0) void'(exp_q.pop_front());
        end
      end
      if (iv0 && ir_exp) begin
        exp_q.push_back(d0);
        m_occ = 1'b1;
      end else if (m_occ && or0) begin
        m_occ = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    chk("u0_queue_empty", DW'(exp_q.size()), '0);

    // reset asserted mid-transfer on u1 with two entries held
    step1(1'b1, D1, 1'b0, 1'b0, 1'b0, 1'b0);
    step1(1'b1, D2, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("pre_rst_occupancy", DW'(occ1), DW'(2'd2));
    #2;
    resetn = 1'b0;
    #1;
    chk_u1("midrst", 1'b0, 2'd0, 1'b1, 4'd0);
    chk("midrst_out_data", bus1.out_data, '0);
    @(negedge clk);
    resetn = 1'b1;
    step1(1'b0, DX, 1'b0, 1'b1, 1'b0, 1'b0);
    chk_u1("postrst", 1'b0, 2'd0, 1'b1, 4'd0);

    // ---------------- final report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
